// File: rtl/data_mem_unit.sv
// data_mem_unit: byte-addressed data memory for the MIPS MEM stage.
// Supports byte/half/word loads and stores with sign or zero extension,
// a req/ready handshake with WAIT_CYCLES wait states, and error reporting
// for illegal sizes, misaligned accesses and out-of-range addresses.
module data_mem_unit #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LOW_W = IDX_W + 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Request captured at acceptance; only consulted while in WAIT.
  logic              we_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic             accept;
  logic             do_access;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             out_of_range;
  logic             bad;
  logic [3:0]       be;
  logic [31:0]      wword;
  logic [31:0]      rd_word;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      load_v;

  assign accept    = req && (state_q == S_IDLE || state_q == S_RESP);
  assign do_access = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign idx       = addr_q[LOW_W-1:2];
  assign lane      = addr_q[1:0];
  assign rd_word   = mem[idx];

  // Any address bit above the array span means the access is out of range.
  if (ADDR_W > LOW_W) begin : g_range
    assign out_of_range = |addr_q[ADDR_W-1:LOW_W];
  end else begin : g_no_range
    assign out_of_range = 1'b0;
  end

  // State register and wait counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE/RESP, count down in WAIT.
  // NOTE: every combinational output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = S_RESP;
      end
      S_RESP: begin
        if (req) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; err only qualifies the ready pulse.
  always_comb begin
    ready = (state_q == S_RESP);
    busy  = (state_q == S_WAIT);
    err   = (state_q == S_RESP) && err_q;
    rdata = rdata_q;
  end

  // Capture the request fields when a request is accepted.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      we_q    <= we;
      size_q  <= size;
      sext_q  <= sext;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Decode size/lane into a legality flag, byte enables and replicated data.
  always_comb begin
    bad   = 1'b0;
    be    = 4'b0000;
    wword = wdata_q;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        bad   = lane[0];
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        bad = (lane != 2'b00);
        be  = 4'b1111;
      end
      default: bad = 1'b1;
    endcase
    bad = bad | out_of_range;
  end

  // Extract the addressed lane(s) and extend to 32 bits.
  always_comb begin
    byte_v = rd_word[{lane, 3'b000} +: 8];
    half_v = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      2'b00:   load_v = {{24{sext_q & byte_v[7]}}, byte_v};
      2'b01:   load_v = {{16{sext_q & half_v[15]}}, half_v};
      default: load_v = rd_word;
    endcase
  end

  // Result update on completion: errors force zero, stores keep rdata.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (do_access) begin
      err_d = bad;
      if (bad)        rdata_d = '0;
      else if (!we_q) rdata_d = load_v;
    end
  end

  // Result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Lane-masked array write; commits on the edge that raises ready.
  // NOTE: the storage array is deliberately not reset; only control state is.
  always_ff @(posedge clk) begin
    if (!rst && do_access && we_q && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed testbench for data_mem_unit. Three instances cover
// WAIT_CYCLES = 1 (dut 0), 0 (dut 1) and 3 (dut 2).
module tb_data_mem_unit;

  logic        clk;
  logic        rst_s   [3];
  logic        req_s   [3];
  logic        we_s    [3];
  logic [1:0]  size_s  [3];
  logic        sext_s  [3];
  logic [31:0] addr_s  [3];
  logic [31:0] wdata_s [3];
  logic [31:0] rdata_s [3];
  logic        ready_s [3];
  logic        err_s   [3];
  logic        busy_s  [3];

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

  data_mem_unit #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst_s[0]), .req(req_s[0]), .we(we_s[0]), .size(size_s[0]),
    .sext(sext_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]),
    .ready(ready_s[0]), .err(err_s[0]), .busy(busy_s[0]));

  data_mem_unit #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .req(req_s[1]), .we(we_s[1]), .size(size_s[1]),
    .sext(sext_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]),
    .ready(ready_s[1]), .err(err_s[1]), .busy(busy_s[1]));

  data_mem_unit #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(3)) u_dut2 (
    .clk(clk), .rst(rst_s[2]), .req(req_s[2]), .we(we_s[2]), .size(size_s[2]),
    .sext(sext_s[2]), .addr(addr_s[2]), .wdata(wdata_s[2]), .rdata(rdata_s[2]),
    .ready(ready_s[2]), .err(err_s[2]), .busy(busy_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // One transaction on dut d, starting #1 after an edge. Returns latency in
  // edges after acceptance (-1 on timeout), err, rdata, and whether busy was
  // high throughout WAIT and low at the ready cycle.
  task automatic access(input int d, input logic w, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic e, output logic [31:0] rd,
                        output logic busy_ok);
    req_s[d] = 1'b1; we_s[d] = w; size_s[d] = sz; sext_s[d] = sx;
    addr_s[d] = a; wdata_s[d] = wd;
    @(posedge clk); #1;
    req_s[d] = 1'b0;
    lat = -1; e = 1'bx; rd = 'x; busy_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (busy_s[d] !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      if (ready_s[d] === 1'b1) begin
        lat = n; e = err_s[d]; rd = rdata_s[d];
        if (busy_s[d] !== 1'b0) busy_ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      if ({ready_s[d], err_s[d], busy_s[d]} !== 3'b000) begin
        $display("FAIL reset_flags[%0d]: got %b want 000", d, {ready_s[d], err_s[d], busy_s[d]});
        n_bad++;
      end
      n_cmp++;
      if (rdata_s[d] !== 32'h0) begin
        $display("FAIL reset_rdata[%0d]: got %h want 00000000", d, rdata_s[d]);
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_word();
    int lat; logic e; logic [31:0] rd; logic bok;
    access(0, 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, lat, e, rd, bok);
    if (lat !== 2) begin $display("FAIL word_store_latency: got %0d want 2", lat); n_bad++; end
    n_cmp++;
    if (e !== 1'b0) begin $display("FAIL word_store_err: got %b want 0", e); n_bad++; end
    n_cmp++;
    if (bok !== 1'b1) begin $display("FAIL word_store_busy: got %b want 1", bok); n_bad++; end
    n_cmp++;
    access(0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, lat, e, rd, bok);
    if (rd !== 32'hDEADBEEF) begin $display("FAIL word_load: got %h want deadbeef", rd); n_bad++; end
    n_cmp++;
    // Upper boundary of the array is a legal word.
    access(0, 1'b1, SZ_W, 1'b0, 32'h3FC, 32'h0BADF00D, lat, e, rd, bok);
    access(0, 1'b0, SZ_W, 1'b0, 32'h3FC, 32'h0, lat, e, rd, bok);
    if ({e, rd} !== {1'b0, 32'h0BADF00D}) begin
      $display("FAIL word_top: got err=%b %h want err=0 0badf00d", e, rd); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_subword();
    int lat; logic e; logic [31:0] rd; logic bok;
    logic [31:0] a_tab  [6] = '{32'h23, 32'h23, 32'h20, 32'h22, 32'h21, 32'h22};
    logic [1:0]  sz_tab [6] = '{SZ_B, SZ_B, SZ_H, SZ_H, SZ_B, SZ_H};
    logic        sx_tab [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] ex_tab [6] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F02,
                                32'hFFFF80F1, 32'h0000007F, 32'h000080F1};
    access(0, 1'b1, SZ_W, 1'b0, 32'h20, 32'h80F17F02, lat, e, rd, bok);
    for (int i = 0; i < 6; i++) begin
      access(0, 1'b0, sz_tab[i], sx_tab[i], a_tab[i], 32'h0, lat, e, rd, bok);
      if ({e, rd} !== {1'b0, ex_tab[i]}) begin
        $display("FAIL subword_load[%0d]: got err=%b %h want err=0 %h", i, e, rd, ex_tab[i]);
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_partial();
    int lat; logic e; logic [31:0] rd; logic bok;
    // rdata still holds 000080F1 from the last subword load.
    access(0, 1'b1, SZ_W, 1'b0, 32'h30, 32'h00000000, lat, e, rd, bok);
    access(0, 1'b1, SZ_B, 1'b0, 32'h31, 32'hFFFFFFAB, lat, e, rd, bok);
    access(0, 1'b1, SZ_H, 1'b0, 32'h32, 32'hFFFF1234, lat, e, rd, bok);
    if (rd !== 32'h000080F1) begin $display("FAIL store_keeps_rdata: got %h want 000080f1", rd); n_bad++; end
    n_cmp++;
    access(0, 1'b0, SZ_W, 1'b0, 32'h30, 32'h0, lat, e, rd, bok);
    if (rd !== 32'h1234AB00) begin $display("FAIL partial_store: got %h want 1234ab00", rd); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_errors();
    int lat; logic e; logic [31:0] rd; logic bok;
    logic        w_tab  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0]  sz_tab [5] = '{SZ_W, SZ_H, SZ_X, SZ_W, SZ_W};
    logic [31:0] a_tab  [5] = '{32'h06, 32'h41, 32'h40, 32'h400, 32'h440};
    access(0, 1'b1, SZ_W, 1'b0, 32'h40, 32'hCAFEF00D, lat, e, rd, bok);
    for (int i = 0; i < 5; i++) begin
      // Preload rdata with a nonzero value so the forced zero is visible.
      access(0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, lat, e, rd, bok);
      access(0, w_tab[i], sz_tab[i], 1'b0, a_tab[i], 32'h11111111, lat, e, rd, bok);
      if ({lat == 2, e, rd} !== {1'b1, 1'b1, 32'h0}) begin
        $display("FAIL error_case[%0d]: got lat=%0d err=%b %h want lat=2 err=1 00000000",
                 i, lat, e, rd);
        n_bad++;
      end
      n_cmp++;
    end
    access(0, 1'b0, SZ_W, 1'b0, 32'h40, 32'h0, lat, e, rd, bok);
    if ({e, rd} !== {1'b0, 32'hCAFEF00D}) begin
      $display("FAIL error_no_write: got err=%b %h want err=0 cafef00d", e, rd); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    int lat; logic e; logic [31:0] rd; logic bok;
    logic [31:0] val [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hDDDDDDDD};
    logic [2:0]  obs [7];
    logic [31:0] got [3];
    logic [2:0]  exp_obs [7] = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b000};
    int k;
    for (int i = 0; i < 4; i++)
      access(1, 1'b1, SZ_W, 1'b0, 32'(4 * i), val[i], lat, e, rd, bok);
    if (lat !== 1) begin $display("FAIL b2b_latency_wc0: got %0d want 1", lat); n_bad++; end
    n_cmp++;
    req_s[1] = 1'b1; we_s[1] = 1'b0; size_s[1] = SZ_W; addr_s[1] = 32'h0;
    k = 0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      obs[c] = {ready_s[1], err_s[1], busy_s[1]};
      if (ready_s[1] === 1'b1 && k < 3) begin got[k] = rdata_s[1]; k++; end
      // While busy, present a decoy address; in RESP, present the next one.
      if (busy_s[1] === 1'b1) addr_s[1] = 32'h0C;
      else                    addr_s[1] = 32'(4 * k);
      if (c == 5) req_s[1] = 1'b0;
    end
    for (int c = 0; c < 7; c++) begin
      if (obs[c] !== exp_obs[c]) begin
        $display("FAIL b2b_flags[E%0d]: got %b want %b", c, obs[c], exp_obs[c]); n_bad++;
      end
      n_cmp++;
    end
    for (int i = 0; i < 3; i++) begin
      if (k <= i || got[i] !== val[i]) begin
        $display("FAIL b2b_rdata[%0d]: got %h want %h", i, (k > i) ? got[i] : 32'hx, val[i]);
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic e; logic [31:0] rd; logic bok;
    logic seen_ready;
    access(2, 1'b1, SZ_W, 1'b0, 32'h50, 32'h12345678, lat, e, rd, bok);
    if ({lat == 4, bok} !== 2'b11) begin
      $display("FAIL wc3_latency: got lat=%0d busy_ok=%b want lat=4 busy_ok=1", lat, bok); n_bad++;
    end
    n_cmp++;
    access(2, 1'b0, SZ_W, 1'b0, 32'h50, 32'h0, lat, e, rd, bok);
    req_s[2] = 1'b1; we_s[2] = 1'b1; size_s[2] = SZ_B; addr_s[2] = 32'h50; wdata_s[2] = 32'h55;
    @(posedge clk); #1;           // E0: accepted
    req_s[2] = 1'b0;
    @(posedge clk); #1;           // E1: still waiting
    rst_s[2] = 1'b1;
    @(posedge clk); #1;           // E2: reset sampled
    rst_s[2] = 1'b0;
    if ({ready_s[2], err_s[2], busy_s[2], rdata_s[2]} !== 35'h0) begin
      $display("FAIL abort_outputs: got r/e/b=%b%b%b rdata=%h want 000 00000000",
               ready_s[2], err_s[2], busy_s[2], rdata_s[2]);
      n_bad++;
    end
    n_cmp++;
    seen_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ready_s[2] !== 1'b0) seen_ready = 1'b1;
    end
    if (seen_ready !== 1'b0) begin $display("FAIL abort_no_ready: got %b want 0", seen_ready); n_bad++; end
    n_cmp++;
    access(2, 1'b0, SZ_W, 1'b0, 32'h50, 32'h0, lat, e, rd, bok);
    if (rd !== 32'h12345678) begin $display("FAIL abort_no_write: got %h want 12345678", rd); n_bad++; end
    n_cmp++;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_s[d] = 1'b1; req_s[d] = 1'b0; we_s[d] = 1'b0; size_s[d] = SZ_W;
      sext_s[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;
    @(posedge clk); #1;
    test_word();
    test_subword();
    test_partial();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
